// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal-length XNOR tap masks and the single-step function.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 32;

  // Bit t-1 is set for tap t of the XNOR maximal-length table, for widths 3..32.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] taps;
    taps = '0;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = '0;
    endcase
    return taps;
  endfunction

  // Caller truncates to its own width; taps never reach above it, so upper bits are don't-care.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
    input logic [LFSR_MAX_WIDTH-1:0] state,
    input logic [LFSR_MAX_WIDTH-1:0] taps
  );
    return {state[LFSR_MAX_WIDTH-2:0], ~^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_digit_gen_leap.sv
// Combinational STEPS-fold advance of one XNOR Fibonacci LFSR.
module lfsr_leap
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 4
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] leaped
);

  localparam logic [LFSR_MAX_WIDTH-1:0] Taps = lfsr_taps(WIDTH);

  always_comb begin
    leaped = state;
    for (int unsigned i = 0; i < STEPS; i++) begin
      leaped = WIDTH'(lfsr_step(LFSR_MAX_WIDTH'(leaped), Taps));
    end
  end

endmodule

// File: rtl/lfsr_digit_gen.sv
// Multi-channel pseudo-random digit source with valid/ready output and runtime reseed.
module lfsr_digit_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      DIGIT_W  = 4,
  parameter logic [WIDTH-1:0] SEED     = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          seed_load,
  input  logic [WIDTH-1:0]              seed_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [CHANNELS*DIGIT_W-1:0]   out_data,
  output logic [CHANNELS-1:0]           seed_fixed
);

  logic valid_q, valid_d;
  logic fire;

  assign fire      = valid_q & out_ready;
  assign out_valid = valid_q;

  // A reload withdraws the current word for one cycle so the new stream starts cleanly.
  always_comb begin
    valid_d = ~seed_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gen_ch
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] leaped;
    logic [WIDTH-1:0] rst_seed, load_seed;
    logic             load_lockup;
    logic             fixed_q, fixed_d;

    assign rst_seed    = SEED ^ WIDTH'(k);
    assign load_seed   = seed_in ^ WIDTH'(k);
    assign load_lockup = &load_seed;

    lfsr_leap #(
      .WIDTH (WIDTH),
      .STEPS (DIGIT_W)
    ) u_leap (
      .state  (state_q),
      .leaped (leaped)
    );

    // Reload takes priority over a coincident transfer; the presented word counts as consumed.
    always_comb begin
      state_d = state_q;
      fixed_d = fixed_q;
      if (seed_load) begin
        state_d = load_lockup ? '0 : load_seed;
        fixed_d = fixed_q | load_lockup;
      end else if (fire) begin
        state_d = leaped;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= (&rst_seed) ? '0 : rst_seed;
        fixed_q <= 1'b0;
      end else begin
        state_q <= state_d;
        fixed_q <= fixed_d;
      end
    end

    assign out_data[k*DIGIT_W +: DIGIT_W] = state_q[DIGIT_W-1:0];
    assign seed_fixed[k]                  = fixed_q;
  end

endmodule

// File: tb/tb_lfsr_digit_gen.sv
// Directed and throttled checks of lfsr_digit_gen in two configurations.
module tb_lfsr_digit_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Config A: WIDTH=4, CHANNELS=1, DIGIT_W=1
  logic       a_reset, a_load, a_ready, a_valid;
  logic [3:0] a_seed_in;
  logic [0:0] a_data, a_fixed;

  // Config B: WIDTH=8, CHANNELS=4, DIGIT_W=4
  logic        b_reset, b_load, b_ready, b_valid;
  logic [7:0]  b_seed_in;
  logic [15:0] b_data;
  logic [3:0]  b_fixed;

  lfsr_digit_gen #(
    .WIDTH    (4),
    .CHANNELS (1),
    .DIGIT_W  (1),
    .SEED     (4'h0)
  ) a_dut (
    .clk        (clk),
    .reset      (a_reset),
    .seed_load  (a_load),
    .seed_in    (a_seed_in),
    .out_ready  (a_ready),
    .out_valid  (a_valid),
    .out_data   (a_data),
    .seed_fixed (a_fixed)
  );

  lfsr_digit_gen #(
    .WIDTH    (8),
    .CHANNELS (4),
    .DIGIT_W  (4),
    .SEED     (8'h00)
  ) b_dut (
    .clk        (clk),
    .reset      (b_reset),
    .seed_load  (b_load),
    .seed_in    (b_seed_in),
    .out_ready  (b_ready),
    .out_valid  (b_valid),
    .out_data   (b_data),
    .seed_fixed (b_fixed)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Hand-derived 4-bit XNOR sequence from 0000 (taps 4,3); 1111 absent.
  logic [3:0] seq4 [15];

  task automatic a_stream(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 64'(a_valid), 64'd1);
      check($sformatf("%s_state%0d", tag, i), 64'(a_dut.gen_ch[0].state_q), 64'(seq4[i % 15]));
      check($sformatf("%s_data%0d", tag, i), 64'(a_data), 64'(seq4[i % 15][0]));
      @(negedge clk);
    end
  endtask

  // Reference model for config B
  logic [7:0] m [4];
  logic       mv;
  logic [3:0] mf;

  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], ~^(x & 8'hB8)};
  endfunction

  function automatic logic [15:0] exp_data();
    logic [15:0] d;
    for (int k = 0; k < 4; k++) d[k*4 +: 4] = m[k][3:0];
    return d;
  endfunction

  task automatic b_reset_seq();
    b_reset   = 1'b1;
    b_load    = 1'b0;
    b_ready   = 1'b0;
    b_seed_in = 8'h00;
    @(negedge clk);
    for (int k = 0; k < 4; k++) m[k] = 8'(k);
    mv = 1'b0;
    mf = 4'b0;
    check("b_rst_valid", 64'(b_valid), 64'd0);
    check("b_rst_data", 64'(b_data), 64'h3210);
    check("b_rst_fixed", 64'(b_fixed), 64'd0);
    b_reset = 1'b0;
  endtask

  // Called at a negedge: check outputs, drive inputs, advance the model across the next posedge.
  task automatic b_step(input logic rdy, input logic ld, input logic [7:0] sd, input string tag);
    logic [7:0] x;
    check({tag, "_valid"}, 64'(b_valid), 64'(mv));
    check({tag, "_data"}, 64'(b_data), 64'(exp_data()));
    check({tag, "_fixed"}, 64'(b_fixed), 64'(mf));
    b_ready   = rdy;
    b_load    = ld;
    b_seed_in = sd;
    if (ld) begin
      for (int k = 0; k < 4; k++) begin
        x = sd ^ 8'(k);
        m[k] = (&x) ? 8'h00 : x;
        if (&x) mf[k] = 1'b1;
      end
      mv = 1'b0;
    end else begin
      if (mv && rdy) begin
        for (int k = 0; k < 4; k++) begin
          for (int s = 0; s < 4; s++) m[k] = step8(m[k]);
        end
      end
      mv = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    seq4 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
             4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    a_reset = 1'b1; a_load = 1'b0; a_ready = 1'b1; a_seed_in = 4'h0;
    b_reset = 1'b1; b_load = 1'b0; b_ready = 1'b0; b_seed_in = 8'h00;
    repeat (2) @(negedge clk);

    // A: reset state, then 30 transfers covering two full periods
    check("a_rst_valid", 64'(a_valid), 64'd0);
    check("a_rst_state", 64'(a_dut.gen_ch[0].state_q), 64'h0);
    check("a_rst_fixed", 64'(a_fixed), 64'd0);
    a_reset = 1'b0;
    @(negedge clk);
    a_stream(30, "a_run");

    // A: lock-up seed substitution
    a_load = 1'b1; a_seed_in = 4'hF;
    @(negedge clk);
    a_load = 1'b0;
    check("a_ldF_state", 64'(a_dut.gen_ch[0].state_q), 64'h0);
    check("a_ldF_fixed", 64'(a_fixed), 64'd1);
    check("a_ldF_valid", 64'(a_valid), 64'd0);
    @(negedge clk);
    check("a_ldF_valid2", 64'(a_valid), 64'd1);
    repeat (5) @(negedge clk);

    // A: reset wins over a coincident seed_load; stream restarts from the top
    a_reset = 1'b1; a_load = 1'b1; a_seed_in = 4'h5;
    @(negedge clk);
    check("a_rl_state", 64'(a_dut.gen_ch[0].state_q), 64'h0);
    check("a_rl_valid", 64'(a_valid), 64'd0);
    check("a_rl_fixed", 64'(a_fixed), 64'd0);
    a_reset = 1'b0; a_load = 1'b0;
    @(negedge clk);
    a_stream(15, "a_rerun");

    // B: hold with ready low, then release
    b_reset_seq();
    for (int i = 0; i < 10; i++) b_step(1'b0, 1'b0, 8'h00, $sformatf("b_hold%0d", i));
    check("b_hold_data", 64'(b_data), 64'h3210);
    b_step(1'b1, 1'b0, 8'h00, "b_go");
    check("b_first_leap", 64'(b_data), 64'hDCEF);
    for (int i = 0; i < 8; i++) b_step(1'b1, 1'b0, 8'h00, $sformatf("b_run%0d", i));

    // B: lock-up reseed on channel 0 only
    b_step(1'b1, 1'b1, 8'hFF, "b_ldff");
    check("b_ldff_valid", 64'(b_valid), 64'd0);
    check("b_ldff_data", 64'(b_data), 64'hCDE0);
    check("b_ldff_fixed", 64'(b_fixed), 64'b0001);
    check("b_ldff_ch1", 64'(b_dut.gen_ch[1].state_q), 64'hFE);
    b_step(1'b1, 1'b0, 8'h00, "b_ldff_gap");
    check("b_ldff_valid_back", 64'(b_valid), 64'd1);
    b_step(1'b1, 1'b1, 8'hFF, "b_ldff_again");
    b_step(1'b1, 1'b1, 8'h00, "b_ld00");
    check("b_sticky_fixed", 64'(b_fixed), 64'b0001);
    b_step(1'b1, 1'b0, 8'h00, "b_post0");
    b_step(1'b1, 1'b0, 8'h00, "b_post1");

    // B: seed_load coincident with a transfer
    b_step(1'b1, 1'b1, 8'h5A, "b_ldfire");
    check("b_ldfire_valid", 64'(b_valid), 64'd0);
    check("b_ldfire_data", 64'(b_data), 64'h98BA);
    b_step(1'b1, 1'b0, 8'h00, "b_ldfire_gap");
    check("b_ldfire_first", 64'(b_data), 64'h98BA);
    check("b_ldfire_valid2", 64'(b_valid), 64'd1);
    for (int i = 0; i < 4; i++) b_step(1'b1, 1'b0, 8'h00, $sformatf("b_ldfire_run%0d", i));

    // B: random ready throttling against the unthrottled model
    b_reset_seq();
    for (int i = 0; i < 10000; i++) begin
      b_step(1'($urandom_range(0, 1)), 1'b0, 8'h00, "b_thr");
    end
    b_step(1'b0, 1'b0, 8'h00, "b_thr_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_digit_gen.md
Name: lfsr_digit_gen

Overview:
- Multi-channel, parametrised pseudo-random digit source for the online-arithmetic test harnesses. Drives random operand digit streams into the high-radix online operators.
- Each channel is an independent maximal-length XNOR Fibonacci LFSR. Each channel advances DIGIT_W steps per accepted transfer, so every transfer presents DIGIT_W fresh bits.
- Taps come from a compile-time function, not a data file. Output uses a valid/ready handshake, supports runtime reseeding, and rejects the XNOR lock-up state.

Parameters:
- WIDTH, 32, LFSR length per channel; legal range 3..32.
- CHANNELS, 4, number of independent LFSR channels.
- DIGIT_W, 4, bits emitted per channel per transfer; legal range 1..WIDTH.
- SEED, {WIDTH{1'b0}}, base reset seed; channel k is seeded with SEED ^ k.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- seed_load  in  1  single-cycle pulse: reseed all channels from seed_in
- seed_in  in  WIDTH  base seed for seed_load
- out_ready  in  1  consumer ready
- out_valid  out  1  out_data valid
- out_data  out  CHANNELS*DIGIT_W  channel k digit at bits [k*DIGIT_W +: DIGIT_W]
- seed_fixed  out  CHANNELS  sticky per-channel flag: a lock-up seed was substituted

Behaviour:
- Step function:
  - fb = ~^(state & TAPS(WIDTH)); next = {state[WIDTH-2:0], fb}.
  - All-ones is the only lock-up state.
  - The leap function applies the step DIGIT_W times combinationally.
- out_data for channel k = state_k[DIGIT_W-1:0], driven directly from registers with no combinational path from inputs.
- Reset:
  - state_k <= sanitise(SEED ^ k).
  - out_valid <= 0, seed_fixed <= 0.
  - out_data therefore shows the seed low bits while out_valid is 0.
- sanitise(x): if x is all ones, return all zeros and set seed_fixed[k]; otherwise return x.
- out_valid register:
  - Cleared by reset or seed_load; otherwise set to 1 on the next cycle.
  - First valid data appears exactly 1 cycle after reset deasserts.
- Transfer (fire) = out_valid & out_ready.
  - On fire: state_k <= leap(state_k) for all channels simultaneously.
  - Without fire: state holds and out_data is stable (AXI-style, no change while valid & !ready).
- seed_load:
  - state_k <= sanitise(seed_in ^ k); out_valid <= 0 next cycle, then 1 the cycle after.
  - seed_load beats fire in the same cycle. The current data counts as consumed, and the next presented data is from the new seed.
- seed_load during reset: ignored (reset wins).
- seed_fixed bits are sticky until reset; repeated substitutions keep them set.
- Each channel's period is 2^WIDTH-1 steps. The all-ones state is never presented, since it is unreachable from a sanitised seed.
- Channels share no state. Identical seeds are impossible, because the seeds differ by k in the low bits.

Decomposition:
- Package lfsr_pkg holds:
  - function lfsr_taps(width), returning the maximal-length tap mask (XAPP052 table, 3..32);
  - function lfsr_step(state, taps);
  - constant LFSR_MAX_WIDTH = 32.
- Sub-module lfsr_leap (params WIDTH, STEPS): combinational STEPS-fold step. Instantiated once per channel via a generate loop.
- Top level contains the per-channel state registers, sanitise logic, valid register and handshake.

Test Plan:
1. WIDTH=4, CHANNELS=1, DIGIT_W=1, SEED=0, out_ready=1:
   - Cycle 1 after reset: out_valid=1, digit 0 (state 0000).
   - Following states: 0001, 0011, 0111, 1110, ...
   - Sequence repeats after exactly 15 transfers; 1111 never appears.
2. WIDTH=8, CHANNELS=4, DIGIT_W=4, out_ready held 0 for 10 cycles:
   - out_data constant at the reset-seed nibbles {3,2,1,0}.
   - Raising ready advances each channel by 4 steps per cycle, matching a reference model.
3. seed_load with seed_in=8'hFF, WIDTH=8, CHANNELS=2:
   - Channel 0 loads 00 and seed_fixed=2'b01; channel 1 loads FE.
   - out_valid is 0 for exactly 1 cycle after the load pulse.
4. seed_load and fire in the same cycle:
   - The transfer is counted.
   - The next valid data equals the low bits of sanitise(seed_in ^ k), not the leap of the old state.
5. reset asserted mid-stream with seed_load also high:
   - States return to SEED ^ k, out_valid=0 and seed_fixed=0.
   - Stream restarts identically to scenario 1.
6. Random out_ready throttling over 10,000 cycles:
   - Accepted digit sequence per channel equals the unthrottled reference sequence.
   - No duplicated or skipped digits.
